// File: rtl/isq_pkg.sv
// isq_pkg: shared widths, entry types and age-matrix indexing for the condition-gated issue queue
`ifndef ISQ_DATA_WIDTH
`define ISQ_DATA_WIDTH 16
`endif
`ifndef ISQ_CONDITION_WIDTH
`define ISQ_CONDITION_WIDTH 4
`endif
`ifndef ISQ_INDEX_WIDTH
`define ISQ_INDEX_WIDTH 4
`endif
package isq_pkg;
  typedef logic [`ISQ_DATA_WIDTH-1:0] isq_data_t;
  typedef logic [`ISQ_CONDITION_WIDTH-1:0] isq_cond_t;
  typedef logic [`ISQ_INDEX_WIDTH-1:0] isq_idx_t;
  typedef struct packed {
    logic valid;
    isq_data_t data;
    isq_cond_t cond;
    isq_idx_t index;
  } isq_entry_t;
  // position of pair (i,j), i<j, in row-major upper-triangular storage of an n x n matrix
  function automatic int tri_idx(input int n, input int i, input int j);
    return (j > i) ? i * n - i * (i + 1) / 2 + j - i - 1 : 0;
  endfunction
endpackage

// File: rtl/cq_age_matrix.sv
// cq_age_matrix: pairwise age order over DEPTH slots, grants the oldest ready slot
module cq_age_matrix import isq_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] i_alloc,
  input  logic [DEPTH-1:0] i_free,
  input  logic [DEPTH-1:0] i_ready,
  output logic [DEPTH-1:0] o_grant
);
  localparam int NP = DEPTH * (DEPTH - 1) / 2;
  localparam int IW = NP > 1 ? $clog2(NP) : 1;
  // r_older bit for pair (i,j), i<j, is set when slot i is older than slot j
  logic [NP-1:0] r_older;
  always_ff @(posedge clk)
    if (rst) r_older <= '0;
    else
      for (int i = 0; i < DEPTH; i++)
        for (int j = i + 1; j < DEPTH; j++)
          r_older[IW'(tri_idx(DEPTH, i, j))] <= i_alloc[j] | (~i_alloc[i] &
            (i_free[j] | (~i_free[i] & r_older[IW'(tri_idx(DEPTH, i, j))])));
  always_comb begin
    o_grant = i_ready;
    for (int k = 0; k < DEPTH; k++)
      for (int j = 0; j < DEPTH; j++)
        if (j != k && i_ready[j] && (j < k ? r_older[IW'(tri_idx(DEPTH, j, k))]
                                           : !r_older[IW'(tri_idx(DEPTH, k, j))]))
          o_grant[k] = 1'b0;
  end
endmodule

// File: rtl/isq_cond_queue.sv
// isq_cond_queue: condition-gated issue queue with wakeup broadcast and oldest-ready dequeue
module isq_cond_queue import isq_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int DATA_W = $bits(isq_data_t),
  parameter int COND_W = $bits(isq_cond_t),
  parameter int IDX_W = $bits(isq_idx_t),
  parameter int WAKE_PORTS = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [DATA_W-1:0]            enq_data,
  input  logic [COND_W-1:0]            enq_cond,
  input  logic [IDX_W-1:0]             enq_index,
  input  logic [WAKE_PORTS-1:0]        wake_valid,
  input  logic [WAKE_PORTS*COND_W-1:0] wake_mask,
  input  logic [WAKE_PORTS*COND_W-1:0] wake_value,
  input  logic [WAKE_PORTS*IDX_W-1:0]  wake_index,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [DATA_W-1:0]            deq_data,
  output logic [IDX_W-1:0]             deq_index,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] r_valid;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [COND_W-1:0] r_cond [DEPTH];
  logic [IDX_W-1:0] r_idx [DEPTH];
  logic [OCC_W-1:0] r_occ;
  logic [DEPTH-1:0] w_ready, w_grant, w_alloc, w_free;
  logic [COND_W-1:0] w_enq_cond;
  logic [COND_W-1:0] w_cond [DEPTH];
  logic w_enq, w_deq;
  function automatic logic [COND_W-1:0] upd(input logic [COND_W-1:0] c, m, v);
    return (v & m) | (c & ~m);
  endfunction
  always_comb begin
    w_ready = '0;
    for (int k = 0; k < DEPTH; k++) w_ready[k] = r_valid[k] & (&r_cond[k]);
  end
  cq_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk(clock), .rst(reset), .i_alloc(w_alloc), .i_free(w_free), .i_ready(w_ready), .o_grant(w_grant)
  );
  assign enq_ready = r_occ != OCC_W'(DEPTH);
  assign occupancy = r_occ;
  assign deq_valid = |w_ready;
  assign w_enq = enq_valid & enq_ready & ~flush;
  assign w_deq = deq_valid & deq_ready & ~flush;
  // lowest clear bit of r_valid is the lowest free slot
  assign w_alloc = w_enq ? ~r_valid & (r_valid + DEPTH'(1)) : '0;
  assign w_free = w_deq ? w_grant : '0;
  always_comb begin
    deq_data = '0;
    deq_index = '0;
    for (int k = 0; k < DEPTH; k++) begin
      deq_data = deq_data | (w_grant[k] ? r_data[k] : '0);
      deq_index = deq_index | (w_grant[k] ? r_idx[k] : '0);
    end
  end
  // ports apply in ascending order so the highest port wins overlapping mask bits
  always_comb begin
    w_enq_cond = enq_cond;
    for (int k = 0; k < DEPTH; k++) w_cond[k] = r_cond[k];
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (wake_valid[p] && wake_index[p*IDX_W +: IDX_W] == enq_index)
        w_enq_cond = upd(w_enq_cond, wake_mask[p*COND_W +: COND_W], wake_value[p*COND_W +: COND_W]);
      for (int k = 0; k < DEPTH; k++)
        if (wake_valid[p] && r_valid[k] && r_idx[k] == wake_index[p*IDX_W +: IDX_W])
          w_cond[k] = upd(w_cond[k], wake_mask[p*COND_W +: COND_W], wake_value[p*COND_W +: COND_W]);
    end
  end
  always_ff @(posedge clock)
    if (reset || flush) begin
      r_valid <= '0;
      r_occ <= '0;
    end else begin
      r_valid <= (r_valid & ~w_free) | w_alloc;
      r_occ <= r_occ + OCC_W'(w_enq) - OCC_W'(w_deq);
    end
  always_ff @(posedge clock)
    for (int k = 0; k < DEPTH; k++)
      if (w_alloc[k]) begin
        r_data[k] <= enq_data;
        r_cond[k] <= w_enq_cond;
        r_idx[k] <= enq_index;
      end else r_cond[k] <= w_cond[k];
endmodule
